pacoblaze_io_intc: RTL and testbench
====================================

Name: pacoblaze_io_intc

Overview:
Parametrised port-mapped I/O and interrupt controller between a pacoblaze3 core and the fabric. It replaces hand-written per-design input muxes, output registers and the single-source interrupt latch. It provides up to 8 input ports, up to 8 output registers with readback and write pulses, and an up-to-8-source maskable interrupt controller with per-source edge/level mode. All processor-facing outputs are registered.

Parameters:
NUM_IN, 1, number of 8-bit input ports (1..8)
NUM_OUT, 2, number of 8-bit output registers (1..8)
NUM_IRQ, 1, number of interrupt sources (1..8)
OUT_RESET_VAL, 8'h00, reset value of every output register

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
port_id  input  8  pacoblaze3 port address
write_strobe  input  1  pacoblaze3 write qualifier
read_strobe  input  1  pacoblaze3 read qualifier (no read side effects; informational only)
out_port  input  8  pacoblaze3 write data
in_port  output  8  registered read data to pacoblaze3
in_data  input  8*NUM_IN  fabric input ports, port k = bits [8k+7:8k]
out_data  output  8*NUM_OUT  output registers, port k = bits [8k+7:8k]
out_wr  output  NUM_OUT  one-cycle pulse, bit k high the cycle after register k is written
irq_src  input  NUM_IRQ  asynchronous interrupt sources
interrupt  output  1  to pacoblaze3 interrupt
interrupt_ack  input  1  from pacoblaze3 interrupt_ack

Behaviour:
- Address map: 0x00+k input port k (RO). 0x80+k output reg k (R/W). 0xF0 IRQ_PENDING (R, write-1-to-clear). 0xF1 IRQ_MASK (R/W). 0xF2 IRQ_MODE (R/W, 1=edge, 0=level). 0xF3 IRQ_ACTIVE = pending & mask (RO). Bits at or above NUM_IRQ read 0 and ignore writes.
- Reset values: out_data = OUT_RESET_VAL per port, out_wr=0, in_port=0, pending=0, mask=0, mode=all ones (edge), interrupt=0, sync flops=0.
- Read path: in_port <= mux(port_id) on every clk edge, independent of read_strobe, so latency is 1 cycle. Unmapped or out-of-range addresses (k >= NUM_IN / NUM_OUT) return 8'h00, never X.
- Write path: when write_strobe and port_id = 0x80+k with k < NUM_OUT, register k loads out_port and out_wr[k] pulses one cycle later. Writes to out-of-range or unmapped addresses, including writes to 0x00-0x07 and 0xF3, are ignored.
- Source conditioning, per bit: two-flop synchroniser s1 -> s2, plus a previous-value flop s3.
  - Edge mode: rise = s2 & ~s3 sets pending.
  - Level mode: pending is forced to s2 every cycle.
  - Latency: a source high at clk edge N gives s2 at N+1, pending at N+2, and interrupt at N+3 if unmasked.
- W1C on 0xF0: clears pending bits written as 1.
  - Edge mode: if a rise and a W1C hit the same bit in the same cycle, set wins.
  - Level mode: W1C has no lasting effect while the source stays high.
- Mode change: changing a bit from edge to level takes effect the next cycle. Changing from level to edge leaves pending as-is and does not generate a spurious rise.
- interrupt: registered. Each cycle interrupt <= |(pending & mask), except that in a cycle where interrupt_ack=1, interrupt <= 0. It re-asserts no earlier than the cycle after ack if active bits remain; the core masks it during the ISR.
- Masking: mask does not gate pending capture. Unmasking an already-pending bit asserts interrupt on the next edge.
- Reset mid-operation: all state returns to reset values on the next edge, and the synchronisers discard in-flight edges.

Decomposition:
- Package pacoblaze_io_pkg: address constants (IN_BASE=8'h00, OUT_BASE=8'h80, IRQ_PENDING_ADDR=8'hF0, IRQ_MASK_ADDR=8'hF1, IRQ_MODE_ADDR=8'hF2, IRQ_ACTIVE_ADDR=8'hF3) and the max-port constant 8.
- Sub-module irq_cond_bit: synchroniser, edge detect and pending flop for one source, with mode, W1C-clear and reset inputs. It is instantiated NUM_IRQ times in a generate loop.

Test Plan:
- NUM_IN=2: set in_data=16'hA55A, port_id=0x01 -> in_port=8'hA5 one cycle later. port_id=0x05 -> 8'h00.
- Write 8'h3C to 0x81 with NUM_OUT=2 -> out_data[15:8]=8'h3C and out_wr=2'b10 for exactly one cycle. Read 0x81 returns 8'h3C. A write to 0x83 changes nothing.
- Edge source 0, mask=8'h01: pulse irq_src[0] for 1 cycle at edge N -> pending=8'h01 at N+2, interrupt=1 at N+3. interrupt_ack pulse -> interrupt=0 the next edge. W1C 8'h01 to 0xF0 -> pending=0 and interrupt stays 0.
- Level source 1, mode=8'hFD, mask=8'h02: hold irq_src[1]=1 and W1C 8'h02 -> pending bit 1 stays 1. Drop the source -> pending clears 2 cycles later.
- Same-cycle rise on bit 0 and W1C 8'h01 -> pending bit 0 remains 1. With mask=0 and a pending bit, interrupt=0. Writing mask=8'h01 -> interrupt=1 next edge.
- Assert reset for 1 cycle mid-ISR (interrupt=1, out_data nonzero) -> interrupt=0, pending=0, mask=0, mode=8'hFF and out_data=OUT_RESET_VAL after the edge.

Source files
------------

// File: rtl/pacoblaze_io_pkg.sv
// rtl/pacoblaze_io_pkg.sv - address map and shared helpers for the pacoblaze3 I/O and interrupt controller
package pacoblaze_io_pkg;

  localparam int MAX_PORTS = 8;

  localparam logic [7:0] IN_BASE          = 8'h00;
  localparam logic [7:0] OUT_BASE         = 8'h80;
  localparam logic [7:0] IRQ_PENDING_ADDR = 8'hF0;
  localparam logic [7:0] IRQ_MASK_ADDR    = 8'hF1;
  localparam logic [7:0] IRQ_MODE_ADDR    = 8'hF2;
  localparam logic [7:0] IRQ_ACTIVE_ADDR  = 8'hF3;

  function automatic logic [7:0] port_addr(input logic [7:0] base, input int k);
    return base + k[7:0];
  endfunction

endpackage

// File: rtl/irq_cond_bit.sv
// rtl/irq_cond_bit.sv - synchroniser, edge detect and pending flop for one interrupt source
module irq_cond_bit (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  input  logic edge_mode_i,
  input  logic clr_i,
  output logic pending_o
);

  logic s1_q, s2_q, s3_q;
  logic pending_q, pending_d;

  // s3 always follows s2, so a level->edge switch sees no artificial rise
  always_comb begin
    pending_d = pending_q;
    if (!edge_mode_i) begin
      pending_d = s2_q;
    end else if (s2_q && !s3_q) begin
      pending_d = 1'b1;
    end else if (clr_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      s1_q      <= src_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/pacoblaze_io_intc.sv
// rtl/pacoblaze_io_intc.sv - port-mapped I/O registers and maskable interrupt controller for pacoblaze3
module pacoblaze_io_intc
  import pacoblaze_io_pkg::*;
#(
  parameter int         NUM_IN        = 1,
  parameter int         NUM_OUT       = 2,
  parameter int         NUM_IRQ       = 1,
  parameter logic [7:0] OUT_RESET_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           out_port,
  output logic [7:0]           in_port,
  input  logic [8*NUM_IN-1:0]  in_data,
  output logic [8*NUM_OUT-1:0] out_data,
  output logic [NUM_OUT-1:0]   out_wr,
  input  logic [NUM_IRQ-1:0]   irq_src,
  output logic                 interrupt,
  input  logic                 interrupt_ack
);

  logic [8*NUM_OUT-1:0] out_q, out_d;
  logic [NUM_OUT-1:0]   out_wr_q, out_wr_d;
  logic [7:0]           in_port_q, in_port_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   mode_q, mode_d;
  logic [NUM_IRQ-1:0]   pending;
  logic [NUM_IRQ-1:0]   clr;
  logic                 int_q, int_d;
  logic [7:0]           pending8, mask8, mode8;
  logic                 unused_read;

  assign unused_read = read_strobe;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
      irq_cond_bit u_cond (
        .clk         (clk),
        .reset       (reset),
        .src_i       (irq_src[gi]),
        .edge_mode_i (mode_q[gi]),
        .clr_i       (clr[gi]),
        .pending_o   (pending[gi])
      );
    end
  endgenerate

  // Unimplemented IRQ bits read back as zero
  always_comb begin
    pending8 = 8'h00;
    mask8    = 8'h00;
    mode8    = 8'h00;
    pending8[NUM_IRQ-1:0] = pending;
    mask8[NUM_IRQ-1:0]    = mask_q;
    mode8[NUM_IRQ-1:0]    = mode_q;
  end

  always_comb begin
    in_port_d = 8'h00;
    for (int k = 0; k < NUM_IN; k++) begin
      if (port_id == port_addr(IN_BASE, k)) in_port_d = in_data[8*k +: 8];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (port_id == port_addr(OUT_BASE, k)) in_port_d = out_q[8*k +: 8];
    end
    case (port_id)
      IRQ_PENDING_ADDR: in_port_d = pending8;
      IRQ_MASK_ADDR:    in_port_d = mask8;
      IRQ_MODE_ADDR:    in_port_d = mode8;
      IRQ_ACTIVE_ADDR:  in_port_d = pending8 & mask8;
      default: ;
    endcase
  end

  always_comb begin
    out_d    = out_q;
    out_wr_d = '0;
    mask_d   = mask_q;
    mode_d   = mode_q;
    clr      = '0;
    if (write_strobe) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (port_id == port_addr(OUT_BASE, k)) begin
          out_d[8*k +: 8] = out_port;
          out_wr_d[k]     = 1'b1;
        end
      end
      case (port_id)
        IRQ_PENDING_ADDR: clr    = out_port[NUM_IRQ-1:0];
        IRQ_MASK_ADDR:    mask_d = out_port[NUM_IRQ-1:0];
        IRQ_MODE_ADDR:    mode_d = out_port[NUM_IRQ-1:0];
        default: ;
      endcase
    end
    int_d = interrupt_ack ? 1'b0 : |(pending & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= {NUM_OUT{OUT_RESET_VAL}};
      out_wr_q  <= '0;
      in_port_q <= 8'h00;
      mask_q    <= '0;
      mode_q    <= '1;
      int_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_wr_q  <= out_wr_d;
      in_port_q <= in_port_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      int_q     <= int_d;
    end
  end

  assign out_data  = out_q;
  assign out_wr    = out_wr_q;
  assign in_port   = in_port_q;
  assign interrupt = int_q;

endmodule

// File: tb/tb_pacoblaze_io_intc.sv
// tb/tb_pacoblaze_io_intc.sv - self-checking bench for pacoblaze_io_intc
module tb_pacoblaze_io_intc;

  localparam int         NUM_IN  = 2;
  localparam int         NUM_OUT = 2;
  localparam int         NUM_IRQ = 8;
  localparam logic [7:0] RST_VAL = 8'hC3;

  logic        clk = 1'b0;
  logic        reset, write_strobe, read_strobe, interrupt_ack, interrupt;
  logic [7:0]  port_id, out_port, in_port, irq_src;
  logic [15:0] in_data, out_data;
  logic [1:0]  out_wr;

  int vectors = 0;
  int miscompares = 0;

  pacoblaze_io_intc #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .NUM_IRQ(NUM_IRQ), .OUT_RESET_VAL(RST_VAL)
  ) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .in_data(in_data), .out_data(out_data), .out_wr(out_wr), .irq_src(irq_src),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  // Reference model: state after the most recent edge, plus a history of sampled sources
  logic [7:0] m_out [2];
  logic [1:0] m_out_wr;
  logic [7:0] m_in_port, m_pend, m_mask, m_mode;
  logic       m_int;
  logic [7:0] hist [0:8191];
  int         n = 0;
  int         rst_edge = -1;

  // The core sees a source two edges after it was sampled; reset erases everything older
  function automatic logic [7:0] seen(input int i);
    if (i < 0 || i <= rst_edge) return 8'h00;
    return hist[i];
  endfunction

  task automatic tick();
    logic [7:0] rd, s2, s3, clr, np;
    int p;
    p = int'(port_id);
    hist[n] = irq_src;
    if (reset) begin
      rst_edge  = n;
      m_out     = '{RST_VAL, RST_VAL};
      m_out_wr  = 2'b00;
      m_in_port = 8'h00;
      m_pend    = 8'h00;
      m_mask    = 8'h00;
      m_mode    = 8'hFF;
      m_int     = 1'b0;
    end else begin
      rd = 8'h00;
      if (p < NUM_IN) rd = in_data[8*p +: 8];
      else if (p >= 128 && p < 128 + NUM_OUT) rd = m_out[p-128];
      else if (p == 240) rd = m_pend;
      else if (p == 241) rd = m_mask;
      else if (p == 242) rd = m_mode;
      else if (p == 243) rd = m_pend & m_mask;
      s2  = seen(n - 2);
      s3  = seen(n - 3);
      clr = (write_strobe && p == 240) ? out_port : 8'h00;
      np  = (m_mode & ((s2 & ~s3) | (m_pend & ~clr))) | (~m_mode & s2);
      m_int    = interrupt_ack ? 1'b0 : |(m_pend & m_mask);
      m_out_wr = 2'b00;
      if (write_strobe) begin
        if (p >= 128 && p < 128 + NUM_OUT) begin
          m_out[p-128]    = out_port;
          m_out_wr[p-128] = 1'b1;
        end
        if (p == 241) m_mask = out_port;
        if (p == 242) m_mode = out_port;
      end
      m_pend    = np;
      m_in_port = rd;
    end
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++; if (in_port !== 8'h00) begin miscompares++; $display("FAIL reset_in_port got %h want 00", in_port); end
    vectors++; if (out_data !== {RST_VAL, RST_VAL}) begin miscompares++; $display("FAIL reset_out_data got %h want %h", out_data, {RST_VAL, RST_VAL}); end
    vectors++; if (out_wr !== 2'b00) begin miscompares++; $display("FAIL reset_out_wr got %b want 00", out_wr); end
    vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL reset_interrupt got %b want 0", interrupt); end
    port_id = 8'hF2; tick();
    vectors++; if (in_port !== 8'hFF) begin miscompares++; $display("FAIL reset_mode got %h want ff", in_port); end
    port_id = 8'hF1; tick();
    vectors++; if (in_port !== 8'h00) begin miscompares++; $display("FAIL reset_mask got %h want 00", in_port); end
  endtask

  task automatic test_read_inputs();
    in_data = 16'hA55A;
    port_id = 8'h01; tick();
    vectors++; if (in_port !== 8'hA5) begin miscompares++; $display("FAIL read_in1 got %h want a5", in_port); end
    port_id = 8'h05; tick();
    vectors++; if (in_port !== 8'h00) begin miscompares++; $display("FAIL read_in5 got %h want 00", in_port); end
    port_id = 8'h00; tick();
    vectors++; if (in_port !== 8'h5A) begin miscompares++; $display("FAIL read_in0 got %h want 5a", in_port); end
  endtask

  task automatic test_output_write();
    write_reg(8'h81, 8'h3C);
    vectors++; if (out_data !== {8'h3C, RST_VAL}) begin miscompares++; $display("FAIL wr81_data got %h want %h", out_data, {8'h3C, RST_VAL}); end
    vectors++; if (out_wr !== 2'b10) begin miscompares++; $display("FAIL wr81_pulse got %b want 10", out_wr); end
    port_id = 8'h81; tick();
    vectors++; if (out_wr !== 2'b00) begin miscompares++; $display("FAIL wr81_pulse_end got %b want 00", out_wr); end
    vectors++; if (in_port !== 8'h3C) begin miscompares++; $display("FAIL rd81 got %h want 3c", in_port); end
    write_reg(8'h83, 8'hFF);
    write_reg(8'h01, 8'h11);
    write_reg(8'hF3, 8'hFF);
    vectors++; if (out_data !== {8'h3C, RST_VAL}) begin miscompares++; $display("FAIL wr_ignored_data got %h want %h", out_data, {8'h3C, RST_VAL}); end
    vectors++; if (out_wr !== 2'b00) begin miscompares++; $display("FAIL wr_ignored_pulse got %b want 00", out_wr); end
    port_id = 8'hF1; tick();
    vectors++; if (in_port !== 8'h00) begin miscompares++; $display("FAIL wr_f3_mask got %h want 00", in_port); end
  endtask

  task automatic test_edge_irq();
    write_reg(8'hF1, 8'h01);
    irq_src = 8'h01; tick();
    irq_src = 8'h00; tick();
    port_id = 8'hF0; tick();
    vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL edge_early_int got %b want 0", interrupt); end
    tick();
    vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL edge_int got %b want 1", interrupt); end
    vectors++; if (in_port !== 8'h01) begin miscompares++; $display("FAIL edge_pending got %h want 01", in_port); end
    interrupt_ack = 1'b1; write_reg(8'hF0, 8'h01);
    interrupt_ack = 1'b0;
    vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL edge_ack got %b want 0", interrupt); end
    tick();
    vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL edge_after_w1c_int got %b want 0", interrupt); end
    vectors++; if (in_port !== 8'h00) begin miscompares++; $display("FAIL edge_after_w1c_pend got %h want 00", in_port); end
  endtask

  task automatic test_level_irq();
    write_reg(8'hF2, 8'hFD);
    write_reg(8'hF1, 8'h02);
    irq_src = 8'h02;
    tick(); tick(); tick(); tick();
    vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL level_int got %b want 1", interrupt); end
    write_reg(8'hF0, 8'h02);
    tick();
    vectors++; if (in_port !== 8'h02) begin miscompares++; $display("FAIL level_w1c_pend got %h want 02", in_port); end
    irq_src = 8'h00;
    tick(); tick(); tick();
    vectors++; if (in_port !== 8'h02) begin miscompares++; $display("FAIL level_drop_hold got %h want 02", in_port); end
    tick();
    vectors++; if (in_port !== 8'h00) begin miscompares++; $display("FAIL level_drop_clear got %h want 00", in_port); end
  endtask

  task automatic test_set_wins_and_unmask();
    write_reg(8'hF1, 8'h00);
    write_reg(8'hF2, 8'hFF);
    irq_src = 8'h01; tick(); tick();
    write_reg(8'hF0, 8'h01);
    port_id = 8'hF0; tick();
    vectors++; if (in_port !== 8'h01) begin miscompares++; $display("FAIL set_wins_pend got %h want 01", in_port); end
    vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL masked_int got %b want 0", interrupt); end
    write_reg(8'hF1, 8'h01);
    vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL unmask_same_edge got %b want 0", interrupt); end
    port_id = 8'hF3; tick();
    vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL unmask_int got %b want 1", interrupt); end
    vectors++; if (in_port !== 8'h01) begin miscompares++; $display("FAIL active_rd got %h want 01", in_port); end
  endtask

  task automatic test_random();
    logic [7:0] addrs [10];
    addrs = '{8'h00, 8'h01, 8'h02, 8'h80, 8'h81, 8'h82, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
    for (int i = 0; i < 400; i++) begin
      port_id       = ($urandom_range(0, 7) == 0) ? 8'($urandom) : addrs[$urandom_range(0, 9)];
      out_port      = 8'($urandom);
      write_strobe  = ($urandom_range(0, 3) == 0);
      interrupt_ack = ($urandom_range(0, 7) == 0);
      reset         = ($urandom_range(0, 99) == 0);
      in_data       = 16'($urandom);
      irq_src       = irq_src ^ 8'($urandom & $urandom & $urandom);
      tick();
      vectors++; if (in_port !== m_in_port) begin miscompares++; $display("FAIL rand_in_port[%0d] got %h want %h", i, in_port, m_in_port); end
      vectors++; if (out_data !== {m_out[1], m_out[0]}) begin miscompares++; $display("FAIL rand_out_data[%0d] got %h want %h", i, out_data, {m_out[1], m_out[0]}); end
      vectors++; if (out_wr !== m_out_wr) begin miscompares++; $display("FAIL rand_out_wr[%0d] got %b want %b", i, out_wr, m_out_wr); end
      vectors++; if (interrupt !== m_int) begin miscompares++; $display("FAIL rand_interrupt[%0d] got %b want %b", i, interrupt, m_int); end
    end
    reset = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    write_reg(8'h80, 8'h77);
    write_reg(8'hF2, 8'hFF);
    write_reg(8'hF1, 8'hFF);
    irq_src = 8'h00;
    tick(); tick(); tick();
    irq_src = 8'hFF;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (interrupt === 1'b1) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL mid_setup_timeout got interrupt %b want 1 within 8 cycles", interrupt); end
    reset = 1'b1; tick();
    reset = 1'b0;
    vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL mid_interrupt got %b want 0", interrupt); end
    vectors++; if (out_data !== {RST_VAL, RST_VAL}) begin miscompares++; $display("FAIL mid_out_data got %h want %h", out_data, {RST_VAL, RST_VAL}); end
    port_id = 8'hF0; tick();
    vectors++; if (in_port !== 8'h00) begin miscompares++; $display("FAIL mid_pending got %h want 00", in_port); end
    port_id = 8'hF1; tick();
    vectors++; if (in_port !== 8'h00) begin miscompares++; $display("FAIL mid_mask got %h want 00", in_port); end
    port_id = 8'hF2; tick();
    vectors++; if (in_port !== 8'hFF) begin miscompares++; $display("FAIL mid_mode got %h want ff", in_port); end
  endtask

  initial begin
    reset = 1'b1; write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
    port_id = 8'h00; out_port = 8'h00; in_data = 16'h0000; irq_src = 8'h00;
    #2;
    test_reset();
    test_read_inputs();
    test_output_write();
    test_edge_irq();
    test_level_irq();
    test_set_wins_and_unmask();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
